// File: rtl/seq_detector_moore.sv
`default_nettype none
//==============================================================================
// Module   : seq_detector_moore
// Purpose  : Moore-type detector for a runtime-loadable pattern of SEQ_LEN
//            DATA_W-bit symbols. State Sk means the accepted history ends
//            in the first k pattern symbols, with k maximal. The next state
//            comes from a full prefix/suffix search, so the detector never
//            simply restarts on a mismatch. Overlapping matches are optional.
//            An optional saturating match counter is also provided.
// Ports    : clk         - rising-edge clock
//            rst_n       - asynchronous active-low reset
//            en_i        - symbol valid; data_i is sampled only when high
//            data_i      - input symbol
//            load_i      - pattern load strobe (wins over en_i)
//            pattern_i   - pattern; symbol k at [k*DATA_W +: DATA_W]
//            overlap_i   - 1: overlapping matches, 0: restart after a match
//            data_o      - match flag (state == S<SEQ_LEN>)
//            state_o     - current state index (matched prefix length)
//            match_cnt_o - saturating match count
// Config   : SEQ_DETECT_CNT_EN - builds the match counter. When it is left
//            undefined, match_cnt_o is tied to zero.
// Revision : 1.0 - initial release
//==============================================================================
module seq_detector_moore #(
  parameter int DATA_W  = 4,
  parameter int SEQ_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en_i,
  input  logic [DATA_W-1:0]           data_i,
  input  logic                        load_i,
  input  logic [SEQ_LEN*DATA_W-1:0]   pattern_i,
  input  logic                        overlap_i,
  output logic                        data_o,
  output logic [$clog2(SEQ_LEN+1)-1:0] state_o,
  output logic [CNT_W-1:0]            match_cnt_o
);

  localparam int c_state_w = $clog2(SEQ_LEN + 1);

  localparam logic [c_state_w-1:0] c_s0     = '0;
  localparam logic [c_state_w-1:0] c_s_full = c_state_w'(SEQ_LEN);

  logic [SEQ_LEN*DATA_W-1:0] r_pattern;
  logic [c_state_w-1:0]      r_state;
  logic [c_state_w-1:0]      w_next;
  logic [c_state_w-1:0]      w_hist_sel;
  logic [SEQ_LEN:0]          w_sel;

  // w_cand[k][j] is set when the prefix of length j is a suffix of
  // (pattern[0..k-1], data_i). The history is always a pattern prefix, so
  // the "history part" of each check compares the pattern against itself.
  // Those checks are static for a loaded pattern. Only the last symbol
  // compare depends on data_i. Bit 0, the empty prefix, always qualifies.
  logic [SEQ_LEN:0][SEQ_LEN:0] w_cand;

  for (genvar ks = 0; ks <= SEQ_LEN; ks++) begin : g_hist
    for (genvar j = 0; j <= SEQ_LEN; j++) begin : g_len
      if (j == 0) begin : g_empty
        assign w_cand[ks][j] = 1'b1;
      end else if (j <= ks + 1) begin : g_try
        logic [SEQ_LEN-1:0] w_eq;
        for (genvar i = 0; i < SEQ_LEN; i++) begin : g_cmp
          if (i < j - 1) begin : g_chk
            assign w_eq[i] = (r_pattern[i*DATA_W +: DATA_W] ==
                              r_pattern[(ks-j+1+i)*DATA_W +: DATA_W]);
          end else begin : g_pad
            assign w_eq[i] = 1'b1;
          end
        end
        assign w_cand[ks][j] = (&w_eq) &&
                               (r_pattern[(j-1)*DATA_W +: DATA_W] == data_i);
      end else begin : g_none
        assign w_cand[ks][j] = 1'b0;
      end
    end
  end

  // After a full match without overlap the history is discarded. This is the
  // same as searching from S0.
  assign w_hist_sel = ((r_state == c_s_full) && !overlap_i) ? c_s0 : r_state;
  assign w_sel      = w_cand[w_hist_sel];

  // Longest qualifying prefix wins.
  always_comb begin
    w_next = c_s0;
    for (int j = 0; j <= SEQ_LEN; j++) begin
      if (w_sel[c_state_w'(j)]) begin
        w_next = c_state_w'(j);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pattern <= '0;
      r_state   <= c_s0;
    end else if (load_i) begin
      r_pattern <= pattern_i;
      r_state   <= c_s0;
    end else if (en_i) begin
      r_state   <= w_next;
    end
  end

  assign data_o  = (r_state == c_s_full);
  assign state_o = r_state;

`ifdef SEQ_DETECT_CNT_EN
  logic [CNT_W-1:0] r_match_cnt;

  // Counts every accepted entry into the full state, including S_FULL to
  // S_FULL re-matches. It holds at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_match_cnt <= '0;
    end else if (load_i) begin
      r_match_cnt <= '0;
    end else if (en_i && (w_next == c_s_full) && (r_match_cnt != {CNT_W{1'b1}})) begin
      r_match_cnt <= r_match_cnt + 1'b1;
    end
  end

  assign match_cnt_o = r_match_cnt;
`else
  assign match_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_moore.sv
`default_nettype none
//==============================================================================
// Module   : tb_seq_detector_moore
// Purpose  : Self-checking bench for seq_detector_moore (DATA_W=4, SEQ_LEN=4,
//            CNT_W=2). It runs a table of stimulus/expected records through a
//            scoreboard queue. It also has hand-written async-reset and
//            counter-saturation sequences. Expected counts apply only when
//            SEQ_DETECT_CNT_EN is defined, and are zero otherwise.
// Revision : 1.0 - initial release
//==============================================================================
module tb_seq_detector_moore;

  localparam int DATA_W    = 4;
  localparam int SEQ_LEN   = 4;
  localparam int CNT_W     = 2;
  localparam int c_state_w = $clog2(SEQ_LEN + 1);
  localparam int c_pat_w   = SEQ_LEN * DATA_W;

`ifdef SEQ_DETECT_CNT_EN
  localparam bit c_cnt_en = 1'b1;
`else
  localparam bit c_cnt_en = 1'b0;
`endif

  // Patterns packed with symbol 0 (first received) in the low nibble.
  localparam logic [c_pat_w-1:0] c_p1212 = 16'h2121;
  localparam logic [c_pat_w-1:0] c_p1112 = 16'h2111;
  localparam logic [c_pat_w-1:0] c_p1213 = 16'h3121;
  localparam logic [c_pat_w-1:0] c_p3333 = 16'h3333;

  typedef struct {
    int                 tag;
    logic               en;
    logic               load;
    logic               ov;
    logic [DATA_W-1:0]  data;
    logic [c_pat_w-1:0] pat;
    int                 exp_state;
    logic               exp_flag;
    int                 exp_cnt;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 en_i = 1'b0;
  logic [DATA_W-1:0]    data_i = '0;
  logic                 load_i = 1'b0;
  logic [c_pat_w-1:0]   pattern_i = '0;
  logic                 overlap_i = 1'b0;
  logic                 data_o;
  logic [c_state_w-1:0] state_o;
  logic [CNT_W-1:0]     match_cnt_o;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  seq_detector_moore #(
    .DATA_W (DATA_W),
    .SEQ_LEN(SEQ_LEN),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (en_i),
    .data_i     (data_i),
    .load_i     (load_i),
    .pattern_i  (pattern_i),
    .overlap_i  (overlap_i),
    .data_o     (data_o),
    .state_o    (state_o),
    .match_cnt_o(match_cnt_o)
  );

  function automatic vec_t mk(input int tag, input logic en, input logic load,
                              input logic ov, input int data,
                              input logic [c_pat_w-1:0] pat, input int st,
                              input logic fl, input int cnt);
    vec_t v;
    v.tag = tag; v.en = en; v.load = load; v.ov = ov;
    v.data = DATA_W'(data); v.pat = pat;
    v.exp_state = st; v.exp_flag = fl; v.exp_cnt = cnt;
    return v;
  endfunction

  function automatic void add(input int tag, input logic en, input logic load,
                              input logic ov, input int data,
                              input logic [c_pat_w-1:0] pat, input int st,
                              input logic fl, input int cnt);
    vecs.push_back(mk(tag, en, load, ov, data, pat, st, fl, cnt));
  endfunction

  // Pops the oldest expectation and compares it with the current outputs.
  task automatic check_out();
    vec_t                 e;
    logic [CNT_W-1:0]     exp_c;
    logic [c_state_w-1:0] exp_s;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard_empty: output seen with no expectation queued");
      return;
    end
    e     = sb.pop_front();
    exp_s = c_state_w'(e.exp_state);
    exp_c = c_cnt_en ? CNT_W'(e.exp_cnt) : '0;
    if (state_o !== exp_s || data_o !== e.exp_flag || match_cnt_o !== exp_c) begin
      n_err++;
      $display("FAIL vec tag=%0d: got state=%0d flag=%b cnt=%0d, expected state=%0d flag=%b cnt=%0d",
               e.tag, state_o, data_o, match_cnt_o, exp_s, e.exp_flag, exp_c);
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    en_i      = v.en;
    load_i    = v.load;
    overlap_i = v.ov;
    data_i    = v.data;
    pattern_i = v.pat;
    sb.push_back(v);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // tag 1: the pattern register resets to all-zero, so zero symbols match
    add(1, 1, 0, 1, 0, '0, 1, 0, 0);
    add(1, 1, 0, 1, 0, '0, 2, 0, 0);
    add(1, 1, 0, 1, 5, '0, 0, 0, 0);
    // tag 2: overlap on, 1212 then 1,2,1,2,1,2
    add(2, 0, 1, 1, 0, c_p1212, 0, 0, 0);
    add(2, 1, 0, 1, 1, c_p1212, 1, 0, 0);
    add(2, 1, 0, 1, 2, c_p1212, 2, 0, 0);
    add(2, 1, 0, 1, 1, c_p1212, 3, 0, 0);
    add(2, 1, 0, 1, 2, c_p1212, 4, 1, 1);
    add(2, 1, 0, 1, 1, c_p1212, 3, 0, 1);
    add(2, 1, 0, 1, 2, c_p1212, 4, 1, 2);
    // tag 3: overlap off, same stream
    add(3, 0, 1, 0, 0, c_p1212, 0, 0, 0);
    add(3, 1, 0, 0, 1, c_p1212, 1, 0, 0);
    add(3, 1, 0, 0, 2, c_p1212, 2, 0, 0);
    add(3, 1, 0, 0, 1, c_p1212, 3, 0, 0);
    add(3, 1, 0, 0, 2, c_p1212, 4, 1, 1);
    add(3, 1, 0, 0, 1, c_p1212, 1, 0, 1);
    add(3, 1, 0, 0, 2, c_p1212, 2, 0, 1);
    // tag 4: fallback, 1112 with 1,1,1,1,2
    add(4, 0, 1, 1, 0, c_p1112, 0, 0, 0);
    add(4, 1, 0, 1, 1, c_p1112, 1, 0, 0);
    add(4, 1, 0, 1, 1, c_p1112, 2, 0, 0);
    add(4, 1, 0, 1, 1, c_p1112, 3, 0, 0);
    add(4, 1, 0, 1, 1, c_p1112, 3, 0, 0);
    add(4, 1, 0, 1, 2, c_p1112, 4, 1, 1);
    // tag 5: fallback to a shorter prefix, 1213 with 1,2,1,2,1,3
    add(5, 0, 1, 1, 0, c_p1213, 0, 0, 0);
    add(5, 1, 0, 1, 1, c_p1213, 1, 0, 0);
    add(5, 1, 0, 1, 2, c_p1213, 2, 0, 0);
    add(5, 1, 0, 1, 1, c_p1213, 3, 0, 0);
    add(5, 1, 0, 1, 2, c_p1213, 2, 0, 0);
    add(5, 1, 0, 1, 1, c_p1213, 3, 0, 0);
    add(5, 1, 0, 1, 3, c_p1213, 4, 1, 1);
    // tag 6: enable gaps with garbage data
    add(6, 0, 1, 1, 0,  c_p1212, 0, 0, 0);
    add(6, 1, 0, 1, 1,  c_p1212, 1, 0, 0);
    add(6, 0, 0, 1, 7,  c_p1212, 1, 0, 0);
    add(6, 1, 0, 1, 2,  c_p1212, 2, 0, 0);
    add(6, 0, 0, 1, 15, c_p1212, 2, 0, 0);
    add(6, 0, 0, 1, 1,  c_p1212, 2, 0, 0);
    add(6, 1, 0, 1, 1,  c_p1212, 3, 0, 0);
    add(6, 0, 0, 1, 2,  c_p1212, 3, 0, 0);
    add(6, 1, 0, 1, 2,  c_p1212, 4, 1, 1);
    add(6, 0, 0, 1, 1,  c_p1212, 4, 1, 1);
    add(6, 0, 0, 1, 3,  c_p1212, 4, 1, 1);
    // tag 7: load in S3 with en_i=1 clears state and count, data not consumed
    add(7, 1, 0, 1, 1, c_p1212, 3, 0, 1);
    add(7, 1, 1, 1, 2, c_p1212, 0, 0, 0);
    add(7, 1, 0, 1, 2, c_p1212, 0, 0, 0);
    // tag 8: constant pattern re-matches every symbol, counter saturates
    add(8, 0, 1, 1, 0, c_p3333, 0, 0, 0);
    add(8, 1, 0, 1, 3, c_p3333, 1, 0, 0);
    add(8, 1, 0, 1, 3, c_p3333, 2, 0, 0);
    add(8, 1, 0, 1, 3, c_p3333, 3, 0, 0);
    add(8, 1, 0, 1, 3, c_p3333, 4, 1, 1);
    add(8, 1, 0, 1, 3, c_p3333, 4, 1, 2);
    add(8, 1, 0, 1, 3, c_p3333, 4, 1, 3);
    add(8, 0, 0, 1, 3, c_p3333, 4, 1, 3);
    add(8, 1, 0, 1, 3, c_p3333, 4, 1, 3);
    add(8, 1, 0, 0, 3, c_p3333, 1, 0, 3);

    // Reset phase: the outputs must read as reset while rst_n is held low.
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(mk(0, 0, 0, 0, 0, '0, 0, 0, 0));
    check_out();
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[k]) apply(vecs[k]);

    // tag 9: asynchronous reset while in S3, checked before any clock edge
    apply(mk(9, 0, 1, 1, 0, c_p1212, 0, 0, 0));
    apply(mk(9, 1, 0, 1, 1, c_p1212, 1, 0, 0));
    apply(mk(9, 1, 0, 1, 2, c_p1212, 2, 0, 0));
    apply(mk(9, 1, 0, 1, 1, c_p1212, 3, 0, 0));
    @(negedge clk);
    en_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    sb.push_back(mk(9, 0, 0, 1, 0, c_p1212, 0, 0, 0));
    check_out();
    @(negedge clk);
    rst_n = 1'b1;
    // The pattern register went back to zero with the reset.
    apply(mk(9, 1, 0, 1, 0, c_p1212, 1, 0, 0));

    // tag 10: five non-overlapping matches; counter holds at 3
    apply(mk(10, 0, 1, 0, 0, c_p1212, 0, 0, 0));
    for (int m = 1; m <= 5; m++) begin
      for (int s = 0; s < SEQ_LEN; s++) begin
        int sym;
        int cnt;
        sym = (s % 2 == 0) ? 1 : 2;
        cnt = (s == SEQ_LEN - 1) ? m : m - 1;
        if (cnt > 3) cnt = 3;
        apply(mk(10, 1, 0, 0, sym, c_p1212, s + 1, (s == SEQ_LEN - 1), cnt));
      end
    end

    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_leftover: %0d expectations never checked, required 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_detector_moore.md
# seq_detector_moore

Parametrised Moore-type sequence detector. It watches a stream of DATA_W-bit symbols and asserts a registered match flag when the last SEQ_LEN accepted symbols equal a runtime-loadable pattern. It supports optional overlapping matches, a sample-enable qualifier, and an optional saturating match counter. It succeeds the fixed 4-bit, fixed-sequence Moore detector and sits directly on a symbol stream, with its output feeding control logic.

## Interface
- DATA_W, 4: symbol width in bits (>=1)
- SEQ_LEN, 4: pattern length in symbols (2..16); FSM has SEQ_LEN+1 states S0..S<SEQ_LEN>
- CNT_W, 8: match counter width (>=1)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- en_i  in  1  symbol-valid; data_i is sampled only when high
- data_i  in  DATA_W  input symbol
- load_i  in  1  pattern load strobe
- pattern_i  in  SEQ_LEN*DATA_W  pattern; symbol k (k=0 received first) at bits [k*DATA_W +: DATA_W]
- overlap_i  in  1  1 = overlapping matches allowed, 0 = detection restarts after a match
- data_o  out  1  match flag, high iff state == S<SEQ_LEN>
- state_o  out  clog2(SEQ_LEN+1)  current state index (= matched prefix length)
- match_cnt_o  out  CNT_W  number of matches (see Configuration)

## Operation
- State Sk means the last accepted symbols end with pattern[0..k-1] and k is maximal.
- Priority per edge: reset > load_i > en_i > hold.
- load_i=1: pattern register <= pattern_i, state <= S0, counter <= 0. data_i is ignored that cycle even if en_i=1.
- en_i=1, load_i=0: next state = length j of the longest pattern prefix that is a suffix of (history of length k, then data_i), capped at SEQ_LEN. Full fallback search is required, not a restart to S0/S1.
  - From Sk with k<SEQ_LEN: history = pattern[0..k-1].
  - From S<SEQ_LEN> with overlap_i=1: history = whole pattern, and j<SEQ_LEN is searched first. A full match is possible again only when the pattern is periodic.
  - From S<SEQ_LEN> with overlap_i=0: history is empty, so the next state is S1 if data_i==pattern[0], else S0.
- en_i=0: state and counter hold.
- data_o is a pure function of registered state (Moore). It has no combinational path from data_i.
- Counter increments by 1 on every accepted transition into S<SEQ_LEN>, including S<SEQ_LEN> to S<SEQ_LEN>. It saturates at 2^CNT_W-1 and does not wrap.
- overlap_i may change at any time. It takes effect on the next accepted symbol.

## Timing
- Reset values: state S0, data_o 0, state_o 0, match_cnt_o 0, pattern register all-zero.
- Reset asserted mid-match forces S0 immediately, without waiting for a clock edge.
- Latency: the final matching symbol is sampled at edge N; data_o is high from edge N until the next accepted symbol edge.
- data_o stays high while en_i=0 in S<SEQ_LEN>. It stays high across consecutive accepted symbols when overlap re-matches (e.g. a constant pattern).
- Load takes effect at the load edge. The first symbol can be accepted on the following edge.

## Configuration
- SEQ_DETECT_CNT_EN defined: match counter is built as described.
- SEQ_DETECT_CNT_EN undefined: counter logic is removed, match_cnt_o is tied to 0, and the port list is unchanged.

## Test plan
All tests use DATA_W=4 and SEQ_LEN=4, with symbols listed in order of arrival.
- Overlap on: load pattern 1,2,1,2 with overlap_i=1, then stream 1,2,1,2,1,2 with en_i=1 -> data_o high after the 4th and 6th symbols; match_cnt_o=2; state_o ends at 4.
- Overlap off: same stream with overlap_i=0 -> data_o high only after the 4th symbol; match_cnt_o=1; state_o ends at 2.
- Fallback: pattern 1,1,1,2, stream 1,1,1,1,2 -> state_o goes 1,2,3,3,4; data_o rises after the 5th symbol.
- Enable gaps: pattern 1,2,1,2, symbols with en_i=0 cycles in between (data_i garbage during gaps) -> state holds across gaps; match flagged after the 4th accepted symbol; data_o stays high through trailing en_i=0 cycles.
- Reset and reload: rst_n low while in S3 -> state_o=0 and data_o=0 immediately. Separately, load_i in S3 with en_i=1 -> state S0, match_cnt_o=0, data_i not consumed.
- Saturation (SEQ_DETECT_CNT_EN defined, CNT_W=2): 5 non-overlapping matches -> match_cnt_o sticks at 3. With the macro undefined, match_cnt_o stays 0 throughout.
